// File: rtl/otter_alu_pkg.sv
// Shared definitions for the OTTER execute-stage ALU with RV32M extension.
// Contents: one-hot op index constants (base ALU ops followed by M-extension
// ops), the control FSM state type, and decode helpers for the multicycle
// op groups.
package otter_alu_pkg;

  localparam int ALU_ADD    = 0;
  localparam int ALU_SLL    = 1;
  localparam int ALU_SLT    = 2;
  localparam int ALU_SLTU   = 3;
  localparam int ALU_XOR    = 4;
  localparam int ALU_SRL    = 5;
  localparam int ALU_OR     = 6;
  localparam int ALU_AND    = 7;
  localparam int ALU_SUB    = 8;
  localparam int ALU_SRA    = 9;
  localparam int ALU_LUI    = 10;
  localparam int ALU_MUL    = 11;
  localparam int ALU_MULH   = 12;
  localparam int ALU_MULHSU = 13;
  localparam int ALU_MULHU  = 14;
  localparam int ALU_DIV    = 15;
  localparam int ALU_DIVU   = 16;
  localparam int ALU_REM    = 17;
  localparam int ALU_REMU   = 18;
  localparam int N_ALU_OPS  = 19;

  typedef enum logic [1:0] {
    IDLE,
    MUL_BUSY,
    DIV_BUSY,
    DIV_FIX
  } state_t;

  function automatic logic is_mul(input logic [N_ALU_OPS-1:0] fun);
    return |fun[ALU_MULHU:ALU_MUL];
  endfunction

  function automatic logic is_div(input logic [N_ALU_OPS-1:0] fun);
    return |fun[ALU_REMU:ALU_DIV];
  endfunction

endpackage

// File: rtl/otter_alu_mdu_divider.sv
// otter_divider: unsigned iterative restoring divider, one quotient bit per
// cycle, XLEN cycles per divide. Sign handling is done by the parent.
// Ports:
//   clk, rst      clock, async active-high reset
//   i_start       load operands and begin iterating
//   i_abort       drop any divide in progress (has priority over i_start)
//   i_dividend    unsigned dividend
//   i_divisor     unsigned divisor (non-zero; zero is resolved by the parent)
//   o_busy        iterations remaining
//   o_done        the final iteration executes this cycle; o_quotient and
//                 o_remainder hold the final values from the next cycle on
//   o_quotient    quotient register
//   o_remainder   remainder register
module otter_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic            i_abort,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_quotient,
  output logic [XLEN-1:0] o_remainder
);

  localparam int CW = $clog2(XLEN) + 1;

  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_dvs;
  logic [XLEN:0]   w_trial;

  // Partial remainder stays below the divisor, so {rem, next bit} - divisor
  // borrows (msb set) exactly when the trial subtraction must be undone.
  assign w_trial = {r_rem, r_quo[XLEN-1]} - {1'b0, r_dvs};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_quo <= '0;
      r_rem <= '0;
      r_dvs <= '0;
    end else if (i_abort) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_quo <= i_dividend;
      r_rem <= '0;
      r_dvs <= i_divisor;
      r_cnt <= CW'(XLEN);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
      if (!w_trial[XLEN]) begin
        r_rem <= w_trial[XLEN-1:0];
        r_quo <= {r_quo[XLEN-2:0], 1'b1};
      end else begin
        r_rem <= {r_rem[XLEN-2:0], r_quo[XLEN-1]};
        r_quo <= {r_quo[XLEN-2:0], 1'b0};
      end
    end
  end

  assign o_busy      = (r_cnt != '0);
  assign o_done      = (r_cnt == CW'(1));
  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;

endmodule

// File: rtl/otter_alu_mdu.sv
// otter_alu_mdu: execute-stage ALU with RV32M multiply/divide.
// Base ops complete in one cycle; MUL* run through a fixed-latency pipeline;
// DIV/REM use the iterative otter_divider plus a sign-fix cycle.
// Ports:
//   clk, rst     clock, async active-high reset
//   valid_i      operation presented this cycle
//   ready_o      high when idle (an op can be accepted)
//   alu_fun_i    one-hot op select (otter_alu_pkg index order) or all-zero
//   op1_i/op2_i  operands
//   flush_i      kill any in-flight op; blocks acceptance this cycle
//   result_o     registered result, held while valid_o is low
//   valid_o      one-cycle pulse marking result_o valid
module otter_alu_mdu
  import otter_alu_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int MUL_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [N_ALU_OPS-1:0] alu_fun_i,
  input  logic [XLEN-1:0]      op1_i,
  input  logic [XLEN-1:0]      op2_i,
  input  logic                 flush_i,
  output logic [XLEN-1:0]      result_o,
  output logic                 valid_o
);

  localparam int SHW   = $clog2(XLEN);
  localparam int PW    = 2 * XLEN;
  localparam int NPIPE = (MUL_LATENCY > 1) ? MUL_LATENCY - 1 : 1;
  localparam int CNTW  = $clog2(MUL_LATENCY + 1);

  state_t          r_state;
  logic [XLEN-1:0] r_result;
  logic            r_valid;
  logic [CNTW-1:0] r_mcnt;
  logic            r_mul_hi;
  logic [PW-1:0]   r_mul_p [NPIPE];
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_is_rem;

  logic            w_accept;
  logic [SHW-1:0]  w_shamt;
  logic [XLEN-1:0] w_sra;
  logic [XLEN-1:0] w_base;

  assign ready_o  = (r_state == IDLE);
  assign result_o = r_result;
  assign valid_o  = r_valid;
  assign w_accept = valid_i & ready_o & ~flush_i;

  // Base ALU: every term gated by its select bit, then XOR-merged.
  assign w_shamt = op2_i[SHW-1:0];
  assign w_sra   = $signed(op1_i) >>> w_shamt;

  always_comb begin
    w_base = '0;
    w_base ^= {XLEN{alu_fun_i[ALU_ADD]}}  & (op1_i + op2_i);
    w_base ^= {XLEN{alu_fun_i[ALU_SLL]}}  & (op1_i << w_shamt);
    w_base ^= {XLEN{alu_fun_i[ALU_SLT]}}  & {{(XLEN-1){1'b0}}, ($signed(op1_i) < $signed(op2_i))};
    w_base ^= {XLEN{alu_fun_i[ALU_SLTU]}} & {{(XLEN-1){1'b0}}, (op1_i < op2_i)};
    w_base ^= {XLEN{alu_fun_i[ALU_XOR]}}  & (op1_i ^ op2_i);
    w_base ^= {XLEN{alu_fun_i[ALU_SRL]}}  & (op1_i >> w_shamt);
    w_base ^= {XLEN{alu_fun_i[ALU_OR]}}   & (op1_i | op2_i);
    w_base ^= {XLEN{alu_fun_i[ALU_AND]}}  & (op1_i & op2_i);
    w_base ^= {XLEN{alu_fun_i[ALU_SUB]}}  & (op1_i - op2_i);
    w_base ^= {XLEN{alu_fun_i[ALU_SRA]}}  & w_sra;
    w_base ^= {XLEN{alu_fun_i[ALU_LUI]}}  & op1_i;
  end

  // Multiplier: (XLEN+1)-bit signed operands (extension bit picks signed vs
  // unsigned), sign-extended to 2*XLEN; the low 2*XLEN product bits are exact.
  logic            w_ext_a;
  logic            w_ext_b;
  logic [PW-1:0]   w_ma;
  logic [PW-1:0]   w_mb;
  logic [PW-1:0]   w_prod;
  logic [XLEN-1:0] w_mul_now;
  logic [PW-1:0]   w_mul_out;
  logic [XLEN-1:0] w_mul_fin;

  assign w_ext_a   = (alu_fun_i[ALU_MULH] | alu_fun_i[ALU_MULHSU]) & op1_i[XLEN-1];
  assign w_ext_b   = alu_fun_i[ALU_MULH] & op2_i[XLEN-1];
  assign w_ma      = {{XLEN{w_ext_a}}, op1_i};
  assign w_mb      = {{XLEN{w_ext_b}}, op2_i};
  assign w_prod    = w_ma * w_mb;
  assign w_mul_now = alu_fun_i[ALU_MUL] ? w_prod[XLEN-1:0] : w_prod[PW-1:XLEN];
  assign w_mul_out = r_mul_p[NPIPE-1];
  assign w_mul_fin = r_mul_hi ? w_mul_out[PW-1:XLEN] : w_mul_out[XLEN-1:0];

  // Free-running product chain; the down-counter picks the stage that lines
  // up with the accepted op, leaving the chain free for retiming.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NPIPE; i++) r_mul_p[i] <= '0;
    end else begin
      r_mul_p[0] <= w_prod;
      for (int unsigned i = 1; i < NPIPE; i++) r_mul_p[i] <= r_mul_p[i-1];
    end
  end

  // Divider operand preparation and special cases.
  logic            w_div_signed;
  logic            w_div_rem;
  logic            w_neg_a;
  logic            w_neg_b;
  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;
  logic            w_div_zero;
  logic            w_div_ovf;
  logic [XLEN-1:0] w_div_spec;
  logic            w_div_start;
  logic            w_div_busy;
  logic            w_div_done;
  logic [XLEN-1:0] w_quo;
  logic [XLEN-1:0] w_rem;
  logic [XLEN-1:0] w_div_fix;

  assign w_div_signed = alu_fun_i[ALU_DIV] | alu_fun_i[ALU_REM];
  assign w_div_rem    = alu_fun_i[ALU_REM] | alu_fun_i[ALU_REMU];
  assign w_neg_a      = w_div_signed & op1_i[XLEN-1];
  assign w_neg_b      = w_div_signed & op2_i[XLEN-1];
  assign w_mag_a      = w_neg_a ? -op1_i : op1_i;
  assign w_mag_b      = w_neg_b ? -op2_i : op2_i;
  assign w_div_zero   = (op2_i == '0);
  assign w_div_ovf    = w_div_signed & (op1_i == {1'b1, {(XLEN-1){1'b0}}}) & (op2_i == '1);
  assign w_div_spec   = w_div_zero ? (w_div_rem ? op1_i : '1)
                                   : (w_div_rem ? '0 : op1_i);
  assign w_div_start  = w_accept & is_div(alu_fun_i) & ~w_div_zero & ~w_div_ovf;
  assign w_div_fix    = r_is_rem ? (r_neg_r ? -w_rem : w_rem)
                                 : (r_neg_q ? -w_quo : w_quo);

  otter_divider #(
    .XLEN(XLEN)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_div_start),
    .i_abort    (flush_i),
    .i_dividend (w_mag_a),
    .i_divisor  (w_mag_b),
    .o_busy     (w_div_busy),
    .o_done     (w_div_done),
    .o_quotient (w_quo),
    .o_remainder(w_rem)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_result <= '0;
      r_valid  <= 1'b0;
      r_mcnt   <= '0;
      r_mul_hi <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_is_rem <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (flush_i) begin
        r_state <= IDLE;
      end else begin
        unique case (r_state)
          IDLE: begin
            if (valid_i) begin
              if (is_mul(alu_fun_i)) begin
                if (MUL_LATENCY == 1) begin
                  r_result <= w_mul_now;
                  r_valid  <= 1'b1;
                end else begin
                  r_mul_hi <= ~alu_fun_i[ALU_MUL];
                  r_mcnt   <= CNTW'(MUL_LATENCY - 1);
                  r_state  <= MUL_BUSY;
                end
              end else if (is_div(alu_fun_i)) begin
                if (w_div_zero | w_div_ovf) begin
                  r_result <= w_div_spec;
                  r_valid  <= 1'b1;
                end else begin
                  r_neg_q  <= w_div_signed & (op1_i[XLEN-1] ^ op2_i[XLEN-1]);
                  r_neg_r  <= w_neg_a;
                  r_is_rem <= w_div_rem;
                  r_state  <= DIV_BUSY;
                end
              end else begin
                r_result <= w_base;
                r_valid  <= 1'b1;
              end
            end
          end
          MUL_BUSY: begin
            r_mcnt <= r_mcnt - 1'b1;
            if (r_mcnt == CNTW'(1)) begin
              r_result <= w_mul_fin;
              r_valid  <= 1'b1;
              r_state  <= IDLE;
            end
          end
          DIV_BUSY: begin
            if (w_div_done || !w_div_busy) r_state <= DIV_FIX;
          end
          DIV_FIX: begin
            r_result <= w_div_fix;
            r_valid  <= 1'b1;
            r_state  <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  a_onehot_fun: assert property (@(posedge clk) disable iff (rst)
    valid_i |-> $onehot0(alu_fun_i));

endmodule
